// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-stage bundle: redirect/stall control from decode, the instruction
// memory request/response pair, and the head-of-queue result.
interface fetch_prefetch_queue_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   pc_chg;
    logic [PC_WIDTH-1:0]    pc_in;
    logic                   stall;
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc_out;
    logic                   instr_valid;
    logic [CNT_W-1:0]       q_count;

    modport master (
        input  pc_chg, pc_in, stall, imem_data,
        output imem_req, imem_addr, instr, pc_out, instr_valid, q_count
    );

    modport slave (
        output pc_chg, pc_in, stall, imem_data,
        input  imem_req, imem_addr, instr, pc_out, instr_valid, q_count
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry prefetch queue; a redirect
// flushes queued and in-flight work and restarts fetch at the new PC.
module fetch_prefetch_queue #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter int PC_STEP     = 1,
    parameter int RESET_PC    = 0
) (
    input  logic                   clk_in,
    input  logic                   RST,
    fetch_prefetch_queue_if.master fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PC_WIDTH-1:0] STEP_V  = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] RESET_V = PC_WIDTH'(RESET_PC);
    localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(DEPTH);

    logic [PC_WIDTH-1:0]    fpc_p0;
    logic                   vld_p1;
    logic [PC_WIDTH-1:0]    pc_p1;
    logic                   flush_pend;
    logic [INSTR_WIDTH-1:0] q_instr [DEPTH];
    logic [PC_WIDTH-1:0]    q_pc    [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       occ;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   not_empty;

    function automatic logic [PC_WIDTH-1:0] next_pc(input logic [PC_WIDTH-1:0] pc);
        return pc + STEP_V;
    endfunction

    // Queue slots plus the outstanding request can never exceed DEPTH, so a
    // response always has a free slot when it lands.
    assign occ       = count + CNT_W'(vld_p1);
    assign issue     = RST && !fq.pc_chg && (occ < DEPTH_C);
    assign push      = vld_p1 && !flush_pend;
    assign not_empty = (count != '0);
    assign pop       = not_empty && !fq.stall;

    assign fq.imem_req    = issue;
    assign fq.imem_addr   = fpc_p0;
    assign fq.instr_valid = not_empty;
    assign fq.instr       = not_empty ? q_instr[rd_ptr] : '0;
    assign fq.pc_out      = not_empty ? q_pc[rd_ptr] : '0;
    assign fq.q_count     = count;

    // Stage p0 -> p1: request issue, response capture and queue bookkeeping
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            fpc_p0     <= RESET_V;
            vld_p1     <= 1'b0;
            flush_pend <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else if (fq.pc_chg) begin
            fpc_p0     <= fq.pc_in;
            vld_p1     <= 1'b0;
            flush_pend <= vld_p1;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            vld_p1     <= issue;
            flush_pend <= 1'b0;
            if (issue) fpc_p0 <= next_pc(fpc_p0);
            if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (issue) pc_p1 <= fpc_p0;
        if (push && !fq.pc_chg) begin
            q_instr[wr_ptr] <= fq.imem_data;
            q_pc[wr_ptr]    <= pc_p1;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: a transaction-level queue model checked every
// cycle on the default build, plus a 4-bit/2-deep build for wrap-around.
module tb_fetch_prefetch_queue;
    logic clk_in = 1'b0;
    logic RST    = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_in = ~clk_in;

    fetch_prefetch_queue_if #(.PC_WIDTH(16), .INSTR_WIDTH(32), .DEPTH(4)) bus ();
    fetch_prefetch_queue_if #(.PC_WIDTH(4),  .INSTR_WIDTH(32), .DEPTH(2)) sbus ();

    fetch_prefetch_queue #(.PC_WIDTH(16), .INSTR_WIDTH(32), .DEPTH(4), .PC_STEP(1), .RESET_PC(0))
        dut (.clk_in(clk_in), .RST(RST), .fq(bus));
    fetch_prefetch_queue #(.PC_WIDTH(4), .INSTR_WIDTH(32), .DEPTH(2), .PC_STEP(1), .RESET_PC(0))
        sdut (.clk_in(clk_in), .RST(RST), .fq(sbus));

    // Synchronous instruction memory: data = {A5A5, addr}, one cycle after request
    always @(posedge clk_in) begin
        if (bus.imem_req)  bus.imem_data  <= {16'hA5A5, bus.imem_addr};
        if (sbus.imem_req) sbus.imem_data <= {16'hA5A5, 12'h000, sbus.imem_addr};
    end

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Model: list of PCs visible to decode, fetch PC, and the one pending response
    logic [15:0] mq[$];
    logic [15:0] m_fpc  = 16'd0;
    logic [15:0] m_rpc  = 16'd0;
    bit          m_infl = 1'b0;
    bit          m_req;
    int          m_n;

    always @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            mq.delete();
            m_fpc  = 16'd0;
            m_infl = 1'b0;
        end else begin
            m_n   = mq.size();
            m_req = !bus.pc_chg && (m_n + int'(m_infl) < 4);
            if (bus.pc_chg) begin
                mq.delete();
                m_fpc  = bus.pc_in;
                m_infl = 1'b0;
            end else begin
                if (m_n > 0 && !bus.stall) void'(mq.pop_front());
                if (m_infl) mq.push_back(m_rpc);
                if (m_req) begin
                    m_rpc  = m_fpc;
                    m_fpc  = m_fpc + 16'd1;
                    m_infl = 1'b1;
                end else begin
                    m_infl = 1'b0;
                end
            end
        end
    end

    // Responses observed in flight, used to assert a push never lands on a full queue
    bit infl_obs = 1'b0, sinfl_obs = 1'b0;
    always @(posedge clk_in) begin
        infl_obs  <= RST && bus.imem_req;
        sinfl_obs <= RST && sbus.imem_req;
    end

    logic        e_v;
    logic [15:0] e_pc;
    always @(negedge clk_in) begin
        e_v  = (mq.size() > 0);
        e_pc = e_v ? mq[0] : 16'd0;
        cmp("m_valid", bus.instr_valid, e_v);
        cmp("m_pc_out", bus.pc_out, e_pc);
        cmp("m_instr", bus.instr, e_v ? {16'hA5A5, e_pc} : 32'd0);
        cmp("m_q_count", bus.q_count, mq.size());
        cmp("m_imem_req", bus.imem_req,
            RST && !bus.pc_chg && (mq.size() + int'(m_infl) < 4));
        cmp("m_imem_addr", bus.imem_addr, m_fpc);
        cmp("q_le_depth", bus.q_count <= 3'd4, 1'b1);
        cmp("s_q_le_depth", sbus.q_count <= 2'd2, 1'b1);
        if (RST) begin
            cmp("push_full", infl_obs && !bus.pc_chg && bus.q_count == 3'd4 && bus.stall, 1'b0);
            cmp("s_push_full", sinfl_obs && sbus.q_count == 2'd2 && sbus.stall, 1'b0);
        end
    end

    task automatic adv();
        @(posedge clk_in);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_in);
    endtask

    logic [3:0] got_s[$];

    initial begin
        bus.pc_chg = 1'b0; bus.pc_in = 16'd0; bus.stall = 1'b0;
        sbus.pc_chg = 1'b0; sbus.pc_in = 4'd0; sbus.stall = 1'b0;
        #2;
        cmp("rst_valid", bus.instr_valid, 1'b0);
        cmp("rst_instr", bus.instr, 32'd0);
        cmp("rst_pc_out", bus.pc_out, 16'd0);
        cmp("rst_q_count", bus.q_count, 3'd0);
        cmp("rst_req", bus.imem_req, 1'b0);
        adv(); adv();
        RST = 1'b1;

        // Fill after reset release
        mid();
        cmp("t1_req", bus.imem_req, 1'b1);
        cmp("t1_addr0", bus.imem_addr, 16'd0);
        cmp("t1_valid0", bus.instr_valid, 1'b0);
        adv(); mid();
        cmp("t1_addr1", bus.imem_addr, 16'd1);
        cmp("t1_valid1", bus.instr_valid, 1'b0);
        adv();
        for (int i = 0; i < 5; i++) begin
            mid();
            cmp("t1_pc_out", bus.pc_out, 16'(i));
            cmp("t1_instr", bus.instr, 32'hA5A50000 + 32'(i));
            adv();
        end

        // Stall until the queue is full, then drain
        bus.stall = 1'b1;
        repeat (6) adv();
        mid();
        cmp("t2_q_full", bus.q_count, 3'd4);
        cmp("t2_req_off", bus.imem_req, 1'b0);
        cmp("t2_pc_held", bus.pc_out, 16'd5);
        cmp("t2_instr_held", bus.instr, 32'hA5A50005);
        adv();
        bus.stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            adv(); mid();
            cmp("t2_drain", bus.pc_out, 16'(6 + i));
        end

        // Redirect with three queued and one in flight
        adv();
        bus.stall = 1'b1;
        adv();
        bus.pc_chg = 1'b1; bus.pc_in = 16'd20;
        mid();
        cmp("t3_pre_q", bus.q_count, 3'd3);
        cmp("t3_pre_pc", bus.pc_out, 16'd11);
        cmp("t3_pre_req", bus.imem_req, 1'b0);
        adv();
        bus.pc_chg = 1'b0; bus.stall = 1'b0;
        mid();
        cmp("t3_q0", bus.q_count, 3'd0);
        cmp("t3_valid0", bus.instr_valid, 1'b0);
        cmp("t3_req", bus.imem_req, 1'b1);
        cmp("t3_addr", bus.imem_addr, 16'd20);
        cmp("t3_pc_zero", bus.pc_out, 16'd0);
        adv(); mid();
        cmp("t3_valid1", bus.instr_valid, 1'b0);
        cmp("t3_addr21", bus.imem_addr, 16'd21);
        adv();
        for (int i = 0; i < 3; i++) begin
            mid();
            cmp("t3_pc_seq", bus.pc_out, 16'(20 + i));
            cmp("t3_valid", bus.instr_valid, 1'b1);
            adv();
        end

        // Back-to-back redirect: the second target wins
        bus.pc_chg = 1'b1; bus.pc_in = 16'd20;
        adv();
        bus.pc_in = 16'd1;
        mid();
        cmp("t4_req_off", bus.imem_req, 1'b0);
        cmp("t4_valid0", bus.instr_valid, 1'b0);
        adv();
        bus.pc_chg = 1'b0;
        mid();
        cmp("t4_addr", bus.imem_addr, 16'd1);
        adv(); mid();
        cmp("t4_valid1", bus.instr_valid, 1'b0);
        adv();
        for (int i = 0; i < 4; i++) begin
            mid();
            cmp("t4_pc_seq", bus.pc_out, 16'(1 + i));
            adv();
        end

        // Asynchronous reset mid-stream with stall and redirect pending
        bus.stall = 1'b1;
        adv(); adv();
        bus.pc_chg = 1'b1; bus.pc_in = 16'd7;
        #1;
        cmp("t6_pre_q", bus.q_count, 3'd3);
        RST = 1'b0;
        #1;
        cmp("t6_valid", bus.instr_valid, 1'b0);
        cmp("t6_instr", bus.instr, 32'd0);
        cmp("t6_pc_out", bus.pc_out, 16'd0);
        cmp("t6_q_count", bus.q_count, 3'd0);
        cmp("t6_req", bus.imem_req, 1'b0);
        mid(); adv();
        bus.pc_chg = 1'b0; bus.stall = 1'b0;
        adv();
        RST = 1'b1;
        mid();
        cmp("t6_addr", bus.imem_addr, 16'd0);
        adv(); adv(); mid();
        cmp("t6_restart_pc", bus.pc_out, 16'd0);
        cmp("t6_restart_v", bus.instr_valid, 1'b1);
        adv(); mid();
        cmp("t6_next_pc", bus.pc_out, 16'd1);

        // 4-bit PC, 2-deep queue: redirect near the top of the PC range
        adv();
        sbus.pc_chg = 1'b1; sbus.pc_in = 4'd14;
        adv();
        sbus.pc_chg = 1'b0;
        mid();
        cmp("t5_addr", sbus.imem_addr, 4'd14);
        cmp("t5_valid0", sbus.instr_valid, 1'b0);
        adv(); adv(); mid();
        cmp("t5_pc14", sbus.pc_out, 4'd14);
        cmp("t5_instr14", sbus.instr, 32'hA5A5000E);
        cmp("t5_q_a", sbus.q_count, 2'd1);
        adv(); mid();
        cmp("t5_pc15", sbus.pc_out, 4'd15);
        cmp("t5_q_b", sbus.q_count, 2'd1);
        adv();
        for (int i = 0; i < 10 && got_s.size() < 2; i++) begin
            mid();
            if (sbus.instr_valid && sbus.pc_out != 4'd15) got_s.push_back(sbus.pc_out);
            adv();
        end
        cmp("t5_count", got_s.size(), 2);
        if (got_s.size() == 2) begin
            cmp("t5_wrap0", got_s[0], 4'd0);
            cmp("t5_wrap1", got_s[1], 4'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
